fifo_af: RTL and testbench
==========================

FIFO_AF -- requirements
Module: fifo_af

Interface
REQ-001 Parameter DATA_W, default 6, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two; ADDR_W = log2(DEPTH).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_L  input  1  asynchronous, active-low reset.
REQ-005 Port push  input  1  write request from arbiter.
REQ-006 Port data_in  input  DATA_W  word written on accepted push.
REQ-007 Port pop  input  1  read request from arbiter.
REQ-008 Port umbral_af  input  ADDR_W+1  almost-full threshold (occupancy).
REQ-009 Port umbral_ae  input  ADDR_W+1  almost-empty threshold (occupancy).
REQ-010 Port data_out  output  DATA_W  word read by last accepted pop (registered).
REQ-011 Port valid_out  output  1  data_out holds a new word this cycle.
REQ-012 Port empty  output  1  occupancy == 0.
REQ-013 Port full  output  1  occupancy == DEPTH.
REQ-014 Port almost_full  output  1  occupancy >= umbral_af.
REQ-015 Port almost_empty  output  1  occupancy <= umbral_ae.
REQ-016 Port error  output  1  sticky: push-on-full or pop-on-empty occurred.

Function
REQ-017 Block SHALL keep wr_ptr, rd_ptr (ADDR_W bits, wrap modulo DEPTH) and count (ADDR_W+1 bits, range 0..DEPTH).
REQ-018 Push SHALL be accepted when push=1 and (full=0 or pop accepted same cycle); accepted push writes data_in at wr_ptr, increments wr_ptr.
REQ-019 Pop SHALL be accepted when pop=1 and empty=0; accepted pop loads mem[rd_ptr] into data_out, increments rd_ptr, asserts valid_out next cycle for exactly one cycle.
REQ-020 Read latency SHALL be one cycle; no fall-through: push into empty FIFO followed by pop in the same cycle SHALL reject the pop.
REQ-021 count SHALL update as +1 push only, -1 pop only, unchanged for both or neither.
REQ-022 Full with push and pop same cycle SHALL accept both, count stays DEPTH, no error.
REQ-023 Push with full=1 and no pop SHALL be dropped (memory, pointers unchanged) and set error.
REQ-024 Pop with empty=1 SHALL be ignored (valid_out=0, data_out holds) and set error.
REQ-025 error SHALL remain 1 until reset_L asserted.
REQ-026 empty, full, almost_full, almost_empty SHALL be combinational decodes of registered count; threshold changes take effect same cycle.
REQ-027 data_out SHALL hold its value between accepted pops.

Reset
REQ-028 reset_L=0 SHALL immediately clear wr_ptr, rd_ptr, count, data_out, valid_out, error; empty=1, full=0.
REQ-029 Memory contents SHALL not be reset; reset mid-operation discards all stored words.
REQ-030 First accepted operation SHALL occur on the first rising edge with reset_L=1.

Structure
REQ-031 Shared package SHALL hold DATA_W and DEPTH defaults and the ADDR_W derivation.
REQ-032 Storage SHALL be a sub-module memoria_fifo (sync write port, sync read port); pointers, count, flags in fifo_af.

Verification
REQ-033 Reset, push 0x01..0x08 on 8 cycles -> full=1 after 8th edge, almost_full=1 from count=umbral_af (6), empty=0.
REQ-034 From full, pop 8 cycles -> data_out 0x01..0x08 in order, valid_out each cycle 1 after pop, empty=1 at end.
REQ-035 Push 9 words with no pop -> 9th dropped, error=1 and stays 1; later pop reads 0x01..0x08 only.
REQ-036 Full FIFO, push=pop=1 with data_in=0x2A -> count stays 8, data_out=0x01, 0x2A read as 8th-next word (pointer wrap).
REQ-037 Empty FIFO, push=pop=1 same cycle -> pop rejected, error=1, count=1, valid_out=0.
REQ-038 Count=5, drop reset_L between edges -> outputs clear immediately, empty=1, subsequent pop sets error.

Source files
------------

// File: rtl/fifo_af_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_af_pkg
//  Description : Shared defaults and address-width derivation for fifo_af.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_af_pkg;

    localparam int DATA_W_DEFAULT = 6;
    localparam int DEPTH_DEFAULT  = 8;

    // Pointer width for a power-of-two depth; a depth of 1 still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int ADDR_W_DEFAULT = addr_w(DEPTH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/fifo_af_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_af_if
//  Description : Arbiter-to-FIFO handshake, thresholds and status bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_af_if
    import fifo_af_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
);
    localparam int ADDR_W = addr_w(DEPTH);

    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [ADDR_W:0]   umbral_af;
    logic [ADDR_W:0]   umbral_ae;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic              error;

    // Arbiter side: issues requests and thresholds, observes status.
    modport master (
        output push, data_in, pop, umbral_af, umbral_ae,
        input  data_out, valid_out, empty, full, almost_full, almost_empty, error
    );

    // FIFO side.
    modport slave (
        input  push, data_in, pop, umbral_af, umbral_ae,
        output data_out, valid_out, empty, full, almost_full, almost_empty, error
    );

endinterface
`default_nettype wire

// File: rtl/fifo_af_memoria_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : memoria_fifo
//  Description : FIFO storage, one synchronous write port and one registered
//                synchronous read port. Array contents are never reset; only
//                the read register is.
//  Revision    : 1.0 - initial release
// ============================================================================
module memoria_fifo
    import fifo_af_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              reset_L,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    input  wire logic              i_rd_en,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write port: storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_af.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_af
//  Description : Synchronous FIFO with programmable almost-full/almost-empty
//                thresholds, registered read data and sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_af
    import fifo_af_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset_L,
    fifo_af_if.slave  bus
);

    localparam int                ADDR_W       = addr_w(DEPTH);
    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_valid;
    logic              r_error;

    logic              w_empty;
    logic              w_full;
    logic              w_pop_acc;
    logic              w_push_acc;
    logic              w_err_evt;
    logic [DATA_W-1:0] w_rd_data;

    // Status decodes of the registered count. Pop acceptance looks only at
    // the registered empty flag, so a word pushed this cycle cannot fall
    // through; push into a full FIFO is allowed only alongside a real pop.
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == c_full_count);
        w_pop_acc  = bus.pop && !w_empty;
        w_push_acc = bus.push && (!w_full || w_pop_acc);
        w_err_evt  = (bus.push && w_full && !w_pop_acc) || (bus.pop && w_empty);
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle valid strobe following each accepted pop, plus sticky error.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= w_pop_acc;
            if (w_err_evt) begin
                r_error <= 1'b1;
            end
        end
    end

    memoria_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset_L   (reset_L),
        .i_wr_en   (w_push_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_pop_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign bus.data_out     = w_rd_data;
    assign bus.valid_out    = r_valid;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= bus.umbral_af);
    assign bus.almost_empty = (r_count <= bus.umbral_ae);
    assign bus.error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fifo_af.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_af
//  Description : Directed self-checking bench for fifo_af (DATA_W=6, DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_af;

    logic clk     = 1'b0;
    logic reset_L = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_af_if #(.DATA_W(6), .DEPTH(8)) bus ();

    fifo_af #(.DATA_W(6), .DEPTH(8)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = '0;
        bus.umbral_af = 4'd6;
        bus.umbral_ae = 4'd2;

        // Reset held across an edge
        tick();
        chk("rst_empty",  32'(bus.empty), 1);
        chk("rst_full",   32'(bus.full), 0);
        chk("rst_error",  32'(bus.error), 0);
        chk("rst_valid",  32'(bus.valid_out), 0);
        chk("rst_dout",   32'(bus.data_out), 0);
        chk("rst_ae",     32'(bus.almost_empty), 1);
        chk("rst_af",     32'(bus.almost_full), 0);
        #4 reset_L = 1'b1;

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            bus.push    = 1'b1;
            bus.data_in = 6'(i);
            tick();
            chk("fill_af",    32'(bus.almost_full), (i >= 6) ? 1 : 0);
            chk("fill_full",  32'(bus.full), (i == 8) ? 1 : 0);
            chk("fill_empty", 32'(bus.empty), 0);
            chk("fill_ae",    32'(bus.almost_empty), (i <= 2) ? 1 : 0);
        end
        bus.push = 1'b0;

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            bus.pop = 1'b1;
            tick();
            chk("drain_valid", 32'(bus.valid_out), 1);
            chk("drain_dout",  32'(bus.data_out), i);
        end
        bus.pop = 1'b0;
        chk("drain_empty", 32'(bus.empty), 1);
        tick();
        chk("drain_valid_low", 32'(bus.valid_out), 0);
        chk("drain_hold",      32'(bus.data_out), 8);
        chk("drain_noerr",     32'(bus.error), 0);

        // Overfill: 9th push dropped
        for (int i = 1; i <= 9; i++) begin
            bus.push    = 1'b1;
            bus.data_in = 6'(i);
            tick();
            chk("ovf_error", 32'(bus.error), (i == 9) ? 1 : 0);
        end
        bus.push = 1'b0;
        chk("ovf_full", 32'(bus.full), 1);
        for (int i = 1; i <= 8; i++) begin
            bus.pop = 1'b1;
            tick();
            chk("ovf_dout",   32'(bus.data_out), i);
            chk("ovf_sticky", 32'(bus.error), 1);
        end
        chk("ovf_empty", 32'(bus.empty), 1);
        // Pop on empty: ignored
        tick();
        chk("udf_valid", 32'(bus.valid_out), 0);
        chk("udf_hold",  32'(bus.data_out), 8);
        chk("udf_error", 32'(bus.error), 1);
        bus.pop = 1'b0;

        // Mid-cycle reset pulse clears error
        reset_L = 1'b0;
        #2;
        chk("rst2_error", 32'(bus.error), 0);
        chk("rst2_dout",  32'(bus.data_out), 0);
        reset_L = 1'b1;

        // Full FIFO, simultaneous push/pop with 0x2A
        for (int i = 1; i <= 8; i++) begin
            bus.push    = 1'b1;
            bus.data_in = 6'(i);
            tick();
        end
        chk("wrap_full0", 32'(bus.full), 1);
        bus.pop     = 1'b1;
        bus.data_in = 6'h2A;
        tick();
        chk("wrap_dout1",  32'(bus.data_out), 1);
        chk("wrap_valid",  32'(bus.valid_out), 1);
        chk("wrap_full",   32'(bus.full), 1);
        chk("wrap_noerr",  32'(bus.error), 0);
        bus.push = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("wrap_dout", 32'(bus.data_out), i);
        end
        tick();
        chk("wrap_2a",    32'(bus.data_out), 32'h2A);
        chk("wrap_empty", 32'(bus.empty), 1);
        chk("wrap_err",   32'(bus.error), 0);

        // Empty FIFO, push and pop together: pop rejected
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.data_in = 6'h15;
        tick();
        chk("nft_valid", 32'(bus.valid_out), 0);
        chk("nft_error", 32'(bus.error), 1);
        chk("nft_empty", 32'(bus.empty), 0);
        chk("nft_ae",    32'(bus.almost_empty), 1);
        chk("nft_hold",  32'(bus.data_out), 32'h2A);
        bus.push = 1'b0;
        tick();
        chk("nft_dout",  32'(bus.data_out), 32'h15);
        chk("nft_empty2", 32'(bus.empty), 1);
        bus.pop = 1'b0;

        // Count 5, then asynchronous reset between edges
        for (int i = 1; i <= 5; i++) begin
            bus.push    = 1'b1;
            bus.data_in = 6'(32'h30 + i);
            tick();
        end
        bus.push = 1'b0;
        bus.umbral_af = 4'd5;
        #1;
        chk("c5_af5", 32'(bus.almost_full), 1);
        bus.umbral_af = 4'd6;
        #1;
        chk("c5_af6", 32'(bus.almost_full), 0);
        bus.umbral_ae = 4'd5;
        #1;
        chk("c5_ae5", 32'(bus.almost_empty), 1);
        bus.umbral_ae = 4'd4;
        #1;
        chk("c5_ae4", 32'(bus.almost_empty), 0);
        reset_L = 1'b0;
        #1;
        chk("ar_empty", 32'(bus.empty), 1);
        chk("ar_full",  32'(bus.full), 0);
        chk("ar_error", 32'(bus.error), 0);
        chk("ar_dout",  32'(bus.data_out), 0);
        chk("ar_valid", 32'(bus.valid_out), 0);
        #1 reset_L = 1'b1;
        bus.pop = 1'b1;
        tick();
        chk("ar_pop_err",   32'(bus.error), 1);
        chk("ar_pop_valid", 32'(bus.valid_out), 0);
        chk("ar_pop_dout",  32'(bus.data_out), 0);
        bus.pop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
